// File: rtl/ldl_p2ram_rs_v2_pkg.sv
// ---------------------------------------------------------------------------
// ldl_p2ram_pkg
// Shared definitions for the ldl_p2ram_rs_v2 pseudo-dual-port RAM:
//   - collision policy encodings (COLL_MODE parameter values)
//   - be_merge(): per-byte-lane merge of a new word over an old word
// ---------------------------------------------------------------------------
package ldl_p2ram_pkg;

   // Collision policy encodings
   localparam int COLL_FLAG        = 0;  // old data, rv suppressed, coll raised
   localparam int COLL_WRITE_FIRST = 1;  // newly written lanes forwarded
   localparam int COLL_READ_FIRST  = 2;  // old data, rv raised, coll raised

   // be_merge works on the widest supported word; callers widen and truncate.
   // MAX_NB must stay 32 because the lane index below is taken as 5 bits.
   localparam int MAX_DW = 256;
   localparam int MAX_NB = 32;

   // Lane i of the result is new_word lane i when be[i] is set, otherwise the
   // old lane. lane_w is the byte-lane width in bits.
   function automatic logic [MAX_DW-1:0] be_merge(
      input logic [MAX_DW-1:0] old_word,
      input logic [MAX_DW-1:0] new_word,
      input logic [MAX_NB-1:0] be,
      input int                lane_w
   );
      logic [MAX_DW-1:0] res;
      int                lane;
      res = old_word;
      if (lane_w > 0) begin
         for (int k = 0; k < MAX_DW; k++) begin
            lane = k / lane_w;
            if (lane < MAX_NB && be[lane[4:0]]) res[k] = new_word[k];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ldl_p2ram_rs_v2_rd_pipe.sv
// ---------------------------------------------------------------------------
// ldl_rd_pipe
// STAGES-deep delay line for read returns. Each stage carries a token (a read
// is present), a collision bit and a data word. Token/collision shift every
// cycle; intermediate data shifts every cycle too, but the final data stage
// only loads when a token arrives so the visible read data holds between
// returns. All stages clear on the asynchronous reset.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   tok_in    in   read issued this cycle
//   coll_in   in   that read collided with a write
//   data_in   in   word captured for that read
//   tok_out   out  token of the last stage
//   coll_out  out  collision bit of the last stage
//   data_out  out  held data of the last stage
// ---------------------------------------------------------------------------
module ldl_rd_pipe #(
   parameter int DW     = 32,
   parameter int STAGES = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tok_in,
   input  logic          coll_in,
   input  logic [DW-1:0] data_in,
   output logic          tok_out,
   output logic          coll_out,
   output logic [DW-1:0] data_out
);

   logic [STAGES-1:0] tok_q;
   logic [STAGES-1:0] coll_q;
   logic [DW-1:0]     data_q [STAGES];

   // Index s of the *_c views is the input of stage s; index STAGES is the
   // output of the last stage.
   logic [STAGES:0]   tok_c;
   logic [STAGES:0]   coll_c;
   logic [DW-1:0]     data_c [STAGES+1];

   assign tok_c  = {tok_q, tok_in};
   assign coll_c = {coll_q, coll_in};

   always_comb begin
      data_c[0] = data_in;
      for (int s = 0; s < STAGES; s++) data_c[s+1] = data_q[s];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_q  <= '0;
         coll_q <= '0;
         for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            tok_q[s]  <= tok_c[s];
            coll_q[s] <= coll_c[s];
            // last stage holds its data unless a read is arriving
            if (s < STAGES - 1 || tok_c[s]) data_q[s] <= data_c[s];
         end
      end
   end

   assign tok_out  = tok_c[STAGES];
   assign coll_out = coll_c[STAGES];
   assign data_out = data_c[STAGES];

endmodule

// File: rtl/ldl_p2ram_rs_v2.sv
// ---------------------------------------------------------------------------
// ldl_p2ram_rs_v2
// Pseudo-dual-port RAM (one write port, one read port, one clock) with
// byte-lane write enables, RD_LAT-cycle pipelined read return, selectable
// same-address collision policy and out-of-range address handling. The
// array itself is never reset; all read-return state is.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   we     in   write request
//   wa     in   write address
//   wbe    in   byte-lane write enables (lane i = din[i*BW +: BW])
//   din    in   write data
//   re     in   read request
//   ra     in   read address
//   dout   out  read data (holds between returns)
//   rv     out  read data valid
//   coll   out  collision flag, aligned with the read return
// ---------------------------------------------------------------------------
module ldl_p2ram_rs_v2
   import ldl_p2ram_pkg::*;
#(
   parameter int DW        = 32,
   parameter int BW        = 8,
   parameter int DEPTH     = 10,
   parameter int AW        = $clog2(DEPTH),
   parameter int RD_LAT    = 1,
   parameter int COLL_MODE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [DW/BW-1:0] wbe,
   input  logic [DW-1:0]    din,
   input  logic             re,
   input  logic [AW-1:0]    ra,
   output logic [DW-1:0]    dout,
   output logic             rv,
   output logic             coll
);

   localparam int            NB      = DW / BW;
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];

   logic          wa_ok;
   logic          ra_ok;
   logic          wr_en;
   logic          collide;
   logic [DW-1:0] old_word;
   logic [DW-1:0] rd_word;
   logic          tok_l;
   logic          coll_l;
   logic [DW-1:0] data_l;

   // DEPTH need not be a power of two, so addresses are range-checked
   assign wa_ok = ({1'b0, wa} < DEPTH_W);
   assign ra_ok = ({1'b0, ra} < DEPTH_W);

   // A write with no lanes enabled touches nothing and cannot collide
   assign wr_en   = we && (|wbe) && wa_ok;
   assign collide = re && wr_en && (ra == wa) && ra_ok;

   assign old_word = ra_ok ? mem[ra] : '0;

   always_comb begin
      rd_word = old_word;
      if (collide && COLL_MODE == COLL_WRITE_FIRST)
         rd_word = DW'(be_merge(MAX_DW'(old_word), MAX_DW'(din),
                                MAX_NB'(wbe), BW));
   end

   // Array write, lane by lane; contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_en && wbe[i]) mem[wa][i*BW +: BW] <= din[i*BW +: BW];
      end
   end

   // Stage 0 samples the (possibly merged) word; the pipe holds all RD_LAT
   // stages so a read issued at edge T is visible after edge T+RD_LAT-1.
   ldl_rd_pipe #(
      .DW     (DW),
      .STAGES (RD_LAT)
   ) u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .tok_in   (re),
      .coll_in  (collide),
      .data_in  (rd_word),
      .tok_out  (tok_l),
      .coll_out (coll_l),
      .data_out (data_l)
   );

   // In FLAG mode a colliding read returns a flag but no valid data
   assign rv   = tok_l && !(COLL_MODE == COLL_FLAG && coll_l);
   assign coll = tok_l && coll_l;
   assign dout = data_l;

endmodule
